sobel_window_sched: RTL and testbench
=====================================

// Module: sobel_window_sched
// PURPOSE
//  Frame-level scheduler for the 3x3 convolution engine. Accepts a raster pixel stream and
//  builds sliding 3x3 windows from two line buffers. Drives the engine's enable_conv/valid_in/data
//  and kernel1..4 inputs, and signals end of frame after the last window has been issued and drained.
//  Sits between the pixel source (camera/DMA) and the convolution engine.
// PARAMETERS
//  IMG_W     640  pixels per line (>=3)
//  IMG_H     480  lines per frame (>=3)
//  CONV_LAT  2    cycles from last valid_in to the engine's final magnitude update
// PORTS
//  clk         in   1    clock
//  reset_n     in   1    asynchronous active-low reset
//  start       in   1    1-cycle pulse; begins a frame when in IDLE
//  pix_data    in   8    unsigned pixel, raster order, row 0 = top
//  pix_valid   in   1    pix_data valid
//  pix_ready   out  1    scheduler can accept a pixel this cycle
//  enable_conv out  1    engine enable
//  valid_in    out  1    data holds a complete window
//  data        out  72   packed window (layout below)
//  kernel1..4  out  27   each; kernel words to engine (0 = engine default Sobel set)
//  busy        out  1    high in every state except IDLE
//  frame_done  out  1    1-cycle pulse at end of frame
//  cfg_we      in   1    [SOBEL_CFG_EN only] kernel register write strobe
//  cfg_sel     in   2    [SOBEL_CFG_EN only] kernel index 0..3 -> kernel1..4
//  cfg_kernel  in   27   [SOBEL_CFG_EN only] kernel write data
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs and counters 0; kernel regs 0. Line-buffer RAM is not reset.
//    Reset mid-frame aborts the frame without a frame_done pulse.
//  - FSM: IDLE -start-> FILL -> RUN -> DRAIN -> DONE -> IDLE.
//    * FILL: row<2, or row==2 && col<2.
//    * RUN: remaining pixels.
//    * Last pixel (col=IMG_W-1, row=IMG_H-1) accepted -> DRAIN.
//    * DRAIN lasts CONV_LAT+1 cycles, then DONE. DONE lasts 1 cycle with frame_done=1.
//  - start outside IDLE is ignored.
//  - pix_ready=1 in FILL/RUN, 0 otherwise. A pixel is accepted on pix_valid&&pix_ready.
//    Gaps in pix_valid stall the counters; no window is issued during a gap.
//  - Counters:
//    * col 0..IMG_W-1 wraps to 0 and increments row; row 0..IMG_H-1.
//    * Widths are $clog2 of the parameter.
//  - Per accepted pixel at (r,c), a new window column is formed:
//    {pix(r,c), linebuf1(c)=row r-1, linebuf0(c)=row r-2}.
//    * Line buffers shift: lb0(c)<=lb1(c), lb1(c)<=pix.
//    * The 3-column window shift register advances one column.
//  - valid_in: registered, asserted exactly 1 cycle after accepting a pixel with r>=2 && c>=2.
//    * No windows straddle the line wrap; (IMG_W-2)*(IMG_H-2) windows per frame.
//  - data layout, mRC = row R, col C of the window (R0 = oldest row, C0 = leftmost):
//    * [7:0]=m00  [15:8]=m10  [23:16]=m20
//    * [31:24]=m01  [39:32]=m11  [47:40]=m21
//    * [55:48]=m02  [63:56]=m12  [71:64]=m22
//    * data holds its value when valid_in=0.
//  - enable_conv=1 in FILL, RUN, DRAIN; 0 in IDLE, DONE.
// CONFIGURATION
//  - SOBEL_CFG_EN defined:
//    * cfg_* ports exist; cfg_we writes cfg_kernel into kernel[cfg_sel] only in IDLE.
//    * Writes while busy are dropped.
//    * kernel1..4 drive the registers, stable for the whole frame.
//  - SOBEL_CFG_EN undefined: cfg_* ports absent; kernel1..4 tied to 27'd0 (engine defaults).
// STRUCTURE
//  - sobel_pkg holds:
//    * PIX_W=8, KERNEL_W=27, WIN_W=72
//    * sched_state_t enum {IDLE,FILL,RUN,DRAIN,DONE}
//    * default Sobel X/Y/diagonal kernel localparams for benches
//  - Sub-module sobel_line_buf: IMG_W-deep, 16-bit wide (two rows) single-port read-before-write RAM.
//    * Addressed by col; returns {lb1,lb0} combinationally or with 0-latency bypass.
// TESTING (IMG_W=5, IMG_H=4 unless noted)
//  - Flat frame:
//    * Stimulus: all pixels 100, continuous pix_valid.
//    * Response: exactly 6 valid_in pulses, every data byte = 100.
//    * frame_done 1 cycle, CONV_LAT+2 cycles after the last pixel; engine magnitude=0.
//  - Ramp frame:
//    * Stimulus: pix = 10*c + r.
//    * Response: first window has m00=0, m02=20, m22=22, m20=2, and col sum pattern matches the layout map.
//  - Backpressure gaps:
//    * Stimulus: pix_valid toggled 1/0 every cycle.
//    * Response: same 6 windows and values as the flat/ramp runs; valid_in never asserted on a gap cycle.
//  - Start while busy:
//    * Stimulus: start pulsed again mid-RUN.
//    * Response: ignored; single frame_done; counters unchanged.
//  - Reset mid-frame:
//    * Stimulus: reset_n low during RUN.
//    * Response: all outputs 0, no frame_done. A following full frame yields 6 correct windows.
//  - SOBEL_CFG_EN:
//    * Stimulus: in IDLE write kernel[2]=27'h1234567; write kernel[0] while busy.
//    * Response: kernel3=27'h1234567 held all frame; kernel1 stays 0.

Source files
------------

// File: rtl/sobel_pkg.sv
// sobel_pkg
//   Shared widths, the scheduler state encoding and reference kernel words
//   for the 3x3 Sobel window scheduler and its benches.
//   Kernel word packing: nine signed 3-bit coefficients, k[R][C] at bit
//   3*(3*R+C), so k00 sits in the least significant bits.
package sobel_pkg;

  localparam int PIX_W    = 8;
  localparam int KERNEL_W = 27;
  localparam int WIN_W    = 72;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  // Sobel X: [-1 0 1; -2 0 2; -1 0 1]
  localparam logic [KERNEL_W-1:0] SOBEL_X_K =
    {3'b001, 3'b000, 3'b111, 3'b010, 3'b000, 3'b110, 3'b001, 3'b000, 3'b111};
  // Sobel Y: [-1 -2 -1; 0 0 0; 1 2 1]
  localparam logic [KERNEL_W-1:0] SOBEL_Y_K =
    {3'b001, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000, 3'b111, 3'b110, 3'b111};
  // Diagonal 45: [0 1 2; -1 0 1; -2 -1 0]
  localparam logic [KERNEL_W-1:0] SOBEL_D45_K =
    {3'b000, 3'b111, 3'b110, 3'b001, 3'b000, 3'b111, 3'b010, 3'b001, 3'b000};
  // Diagonal 135: [-2 -1 0; -1 0 1; 0 1 2]
  localparam logic [KERNEL_W-1:0] SOBEL_D135_K =
    {3'b010, 3'b001, 3'b000, 3'b001, 3'b000, 3'b111, 3'b000, 3'b111, 3'b110};

endpackage

// File: rtl/sobel_window_sched_line_buf.sv
// sobel_line_buf
//   Two-row line buffer: IMG_W entries of {lb1, lb0} (row r-1 in [15:8],
//   row r-2 in [7:0]). Single port, read-before-write: the read is
//   combinational at addr, and a write shifts the entry up by one row
//   (lb0 <= lb1, lb1 <= wr_pix). Contents are not reset.
// Ports
//   clk      in   clock
//   we       in   write (shift) strobe for entry addr
//   addr     in   column index
//   wr_pix   in   incoming pixel, becomes lb1
//   rd_data  out  {lb1, lb0} at addr before this cycle's write
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int AW    = $clog2(IMG_W)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [PIX_W-1:0]   wr_pix,
  output logic [2*PIX_W-1:0] rd_data
);

  logic [2*PIX_W-1:0] mem [IMG_W];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= {wr_pix, mem[addr][2*PIX_W-1:PIX_W]};
  end

endmodule

// File: rtl/sobel_window_sched.sv
// sobel_window_sched
//   Frame scheduler for the 3x3 convolution engine. Accepts a raster pixel
//   stream, forms sliding 3x3 windows from two line buffers and a 2-column
//   shift register, and drives the engine's enable/valid/data/kernel inputs.
//   Signals frame_done once the last window has drained through the engine.
//   Optional feature macro: SOBEL_CFG_EN (runtime kernel registers).
// Parameters
//   IMG_W, IMG_H  frame size (>=3 each); CONV_LAT engine latency
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   frame start pulse (honoured only in IDLE)
//   pix_data/valid/ready    pixel input handshake
//   enable_conv             engine enable (FILL, RUN, DRAIN)
//   valid_in, data          window strobe and packed window, mRC at 24*C+8*R
//   kernel1..kernel4        kernel words (0 = engine default set)
//   busy, frame_done        not-IDLE flag, end-of-frame pulse
//   cfg_we/sel/kernel       kernel register write (SOBEL_CFG_EN only)
module sobel_window_sched
  import sobel_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int CONV_LAT = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [PIX_W-1:0]    pix_data,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic                enable_conv,
  output logic                valid_in,
  output logic [WIN_W-1:0]    data,
  output logic [KERNEL_W-1:0] kernel1,
  output logic [KERNEL_W-1:0] kernel2,
  output logic [KERNEL_W-1:0] kernel3,
  output logic [KERNEL_W-1:0] kernel4,
  output logic                busy,
  output logic                frame_done
`ifdef SOBEL_CFG_EN
  ,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_sel,
  input  logic [KERNEL_W-1:0] cfg_kernel
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int DW = $clog2(CONV_LAT + 2);
  localparam int COL_W = 3 * PIX_W;

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_FILL  = FILL;
  localparam logic [2:0] S_RUN   = RUN;
  localparam logic [2:0] S_DRAIN = DRAIN;
  localparam logic [2:0] S_DONE  = DONE;

  logic [2:0]         state;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [DW-1:0]      drain_cnt;
  logic               acc_p0;
  logic               last_col;
  logic               last_row;
  logic               win_issue_p0;
  logic [2*PIX_W-1:0] lb_rd_p0;
  logic [COL_W-1:0]   new_col_p0;
  logic [COL_W-1:0]   win_c0_p1;
  logic [COL_W-1:0]   win_c1_p1;

  assign pix_ready   = (state == S_FILL) || (state == S_RUN);
  assign busy        = (state != S_IDLE);
  assign enable_conv = (state == S_FILL) || (state == S_RUN) || (state == S_DRAIN);
  assign frame_done  = (state == S_DONE);

  assign acc_p0   = pix_valid && pix_ready;
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));
  // Windows only exist once two full rows and two columns of the current
  // row are present, so none straddle the line wrap.
  assign win_issue_p0 = acc_p0 && (row >= RW'(2)) && (col >= CW'(2));

  // Control: FSM and raster counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FILL;
            col   <= '0;
            row   <= '0;
          end
        end
        S_FILL, S_RUN: begin
          if (acc_p0) begin
            if (last_col) begin
              col <= '0;
              row <= last_row ? '0 : row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            // Next pixel after (2,1) is the first one that completes a window.
            if (state == S_FILL && row == RW'(2) && col == CW'(1))
              state <= S_RUN;
            if (last_col && last_row) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(CONV_LAT)) state <= S_DONE;
          else                            drain_cnt <= drain_cnt + DW'(1);
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  sobel_line_buf #(
    .IMG_W (IMG_W),
    .AW    (CW)
  ) u_line_buf (
    .clk     (clk),
    .we      (acc_p0),
    .addr    (col),
    .wr_pix  (pix_data),
    .rd_data (lb_rd_p0)
  );

  // p0 -> p1: new column {pix, row r-1, row r-2}, oldest row in the low byte
  assign new_col_p0 = {pix_data, lb_rd_p0};

  always_ff @(posedge clk) begin
    if (acc_p0) begin
      win_c0_p1 <= win_c1_p1;
      win_c1_p1 <= new_col_p0;
    end
  end

  // p1: window output register, newest column in the top 24 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_in <= 1'b0;
      data     <= '0;
    end else begin
      valid_in <= win_issue_p0;
      if (win_issue_p0) data <= {new_col_p0, win_c1_p1, win_c0_p1};
    end
  end

`ifdef SOBEL_CFG_EN
  logic [KERNEL_W-1:0] kreg [4];

  // Writes are only honoured in IDLE so the kernels are frozen for a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) kreg[i] <= '0;
    end else if (cfg_we && state == S_IDLE) begin
      kreg[cfg_sel] <= cfg_kernel;
    end
  end

  assign kernel1 = kreg[0];
  assign kernel2 = kreg[1];
  assign kernel3 = kreg[2];
  assign kernel4 = kreg[3];
`else
  assign kernel1 = '0;
  assign kernel2 = '0;
  assign kernel3 = '0;
  assign kernel4 = '0;
`endif

endmodule

// File: tb/tb_sobel_window_sched.sv
// tb_sobel_window_sched
//   Self-checking bench for sobel_window_sched at IMG_W=5, IMG_H=4,
//   CONV_LAT=2. Each frame image is generated up front and the expected
//   windows are taken straight from the image by (row, col) coordinates.
//   Kernel register tests are included when SOBEL_CFG_EN is defined.
module tb_sobel_window_sched;
  import sobel_pkg::*;

  localparam int W    = 5;
  localparam int H    = 4;
  localparam int LAT  = 2;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 2) * (H - 2);

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [PIX_W-1:0]    pix_data = '0;
  logic                pix_valid = 1'b0;
  logic                pix_ready;
  logic                enable_conv;
  logic                valid_in;
  logic [WIN_W-1:0]    data;
  logic [KERNEL_W-1:0] kernel1, kernel2, kernel3, kernel4;
  logic                busy;
  logic                frame_done;
`ifdef SOBEL_CFG_EN
  logic                cfg_we = 1'b0;
  logic [1:0]          cfg_sel = '0;
  logic [KERNEL_W-1:0] cfg_kernel = '0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIN_W-1:0]    held_data = '0;
  logic [KERNEL_W-1:0] kexp [4] = '{default: '0};

  always #5 clk = ~clk;

  sobel_window_sched #(
    .IMG_W    (W),
    .IMG_H    (H),
    .CONV_LAT (LAT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .enable_conv (enable_conv),
    .valid_in    (valid_in),
    .data        (data),
    .kernel1     (kernel1),
    .kernel2     (kernel2),
    .kernel3     (kernel3),
    .kernel4     (kernel4),
    .busy        (busy),
    .frame_done  (frame_done)
`ifdef SOBEL_CFG_EN
    ,
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_kernel  (cfg_kernel)
`endif
  );

  // All control outputs and data must be zero (reset / idle-after-reset).
  task automatic check_all_zero(input string name);
    n_tests++;
    if ({pix_ready, enable_conv, valid_in, busy, frame_done} !== 5'b0 || data !== '0 ||
        {kernel1, kernel2, kernel3, kernel4} !== '0) begin
      n_fail++;
      $display("FAIL %s: ctl=%b data=%h k=%h/%h/%h/%h expected all 0", name,
               {pix_ready, enable_conv, valid_in, busy, frame_done}, data,
               kernel1, kernel2, kernel3, kernel4);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    reset_n   = 1'b1;
    held_data = '0;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  // mode: 0 flat 100, 1 ramp 10*c+r, 2 random
  task automatic run_frame(input int mode, input bit gaps, input bit mid_start,
                           input bit mid_cfg, input string name);
    logic [PIX_W-1:0] img [H][W];
    logic [WIN_W-1:0] expq [$];
    logic [WIN_W-1:0] w;
    int idx, cyc, nwin, last_acc;
    bit exp_vld, acc, done, ms_done, mc_done;

    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (mode == 0) ? 8'd100 :
                    (mode == 1) ? 8'(10 * c + r) : 8'($urandom_range(0, 255));
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        w = '0;
        for (int wr = 0; wr < 3; wr++)
          for (int wc = 0; wc < 3; wc++)
            w[24 * wc + 8 * wr +: 8] = img[r - 2 + wr][c - 2 + wc];
        expq.push_back(w);
      end

    idx = 0; cyc = 0; nwin = 0; last_acc = -100;
    exp_vld = 0; done = 0; ms_done = 0; mc_done = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    pix_valid = 1'b1;
    pix_data  = img[0][0];

    while (!done && cyc < 400) begin
      @(negedge clk);
      n_tests++;
      if (valid_in !== exp_vld) begin
        n_fail++;
        $display("FAIL %s valid_in cyc%0d: got %b want %b", name, cyc, valid_in, exp_vld);
      end
      if (valid_in === 1'b1) begin
        nwin++;
        n_tests++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra window: got %h want none", name, data);
        end else begin
          w = expq.pop_front();
          if (data !== w) begin
            n_fail++;
            $display("FAIL %s window%0d: got %h want %h", name, nwin, data, w);
          end
          held_data = w;
        end
      end else begin
        n_tests++;
        if (data !== held_data) begin
          n_fail++;
          $display("FAIL %s data_hold cyc%0d: got %h want %h", name, cyc, data, held_data);
        end
      end
      n_tests++;
      if ({kernel4, kernel3, kernel2, kernel1} !== {kexp[3], kexp[2], kexp[1], kexp[0]}) begin
        n_fail++;
        $display("FAIL %s kernels: got %h %h %h %h want %h %h %h %h", name,
                 kernel1, kernel2, kernel3, kernel4, kexp[0], kexp[1], kexp[2], kexp[3]);
      end
      if (frame_done === 1'b1) begin
        done = 1;
        n_tests++;
        if (cyc - last_acc != LAT + 2 || enable_conv !== 1'b0 || busy !== 1'b1 || idx != NPIX) begin
          n_fail++;
          $display("FAIL %s frame_done: delay=%0d en=%b busy=%b pix=%0d want delay=%0d en=0 busy=1 pix=%0d",
                   name, cyc - last_acc, enable_conv, busy, idx, LAT + 2, NPIX);
        end
      end
      acc = pix_valid && pix_ready;
      if (acc) begin
        exp_vld  = (idx / W >= 2) && (idx % W >= 2);
        last_acc = cyc;
        idx++;
        n_tests++;
        if (enable_conv !== 1'b1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s en/busy on accept: got %b%b want 11", name, enable_conv, busy);
        end
      end else begin
        exp_vld = 0;
      end

      @(posedge clk); #1;
      start = 1'b0;
      if (mid_start && !ms_done && idx == 13) begin
        start   = 1'b1;
        ms_done = 1;
      end
`ifdef SOBEL_CFG_EN
      cfg_we = 1'b0;
      if (mid_cfg && !mc_done && idx == 5) begin
        cfg_we     = 1'b1;
        cfg_sel    = 2'd0;
        cfg_kernel = 27'h5A5A5A5;
        mc_done    = 1;
      end
`else
      mc_done = mid_cfg;
`endif
      pix_valid = (idx < NPIX) && (!gaps || (cyc % 2 == 1));
      pix_data  = (idx < NPIX) ? img[idx / W][idx % W] : 8'd0;
      cyc++;
    end
    pix_valid = 1'b0;

    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout: got no frame_done want one within 400 cycles", name);
    end
    n_tests++;
    if (nwin != NWIN || expq.size() != 0) begin
      n_fail++;
      $display("FAIL %s window_count: got %0d want %0d", name, nwin, NWIN);
    end
    repeat (4) begin
      @(negedge clk);
      n_tests++;
      if (frame_done !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s post_frame: done=%b busy=%b ready=%b want 000", name,
                 frame_done, busy, pix_ready);
      end
    end
  endtask

  task automatic test_flat();          run_frame(0, 0, 0, 0, "flat");          endtask
  task automatic test_ramp();          run_frame(1, 0, 0, 0, "ramp");          endtask
  task automatic test_gaps();
    run_frame(0, 1, 0, 0, "gaps_flat");
    run_frame(1, 1, 0, 0, "gaps_ramp");
  endtask
  task automatic test_back_to_back(); run_frame(2, 0, 0, 0, "random");        endtask
  task automatic test_start_busy();   run_frame(2, 0, 1, 0, "start_busy");    endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start     = 1'b1;
    pix_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pix_data = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    held_data = '0;
    for (int k = 0; k < 4; k++) kexp[k] = '0;
    check_all_zero("reset_mid_async");
    pix_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("reset_mid_held");
    end
    reset_n = 1'b1;
    run_frame(2, 0, 0, 0, "after_reset");
  endtask

`ifdef SOBEL_CFG_EN
  task automatic test_cfg();
    @(posedge clk); #1;
    cfg_we     = 1'b1;
    cfg_sel    = 2'd2;
    cfg_kernel = 27'h1234567;
    @(posedge clk); #1;
    cfg_we  = 1'b0;
    kexp[2] = 27'h1234567;
    @(negedge clk);
    n_tests++;
    if (kernel3 !== 27'h1234567 || kernel1 !== '0) begin
      n_fail++;
      $display("FAIL cfg_write: got k3=%h k1=%h want 1234567 0", kernel3, kernel1);
    end
    run_frame(1, 0, 0, 1, "cfg_frame");
  endtask
`endif

  initial begin
    test_reset();
    test_flat();
    test_ramp();
    test_gaps();
    test_back_to_back();
    test_start_busy();
    test_reset_mid();
`ifdef SOBEL_CFG_EN
    test_cfg();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
